// File: rtl/ahb_pkg.sv
// ahb_pkg: shared size encodings, arbiter states and master indices.
package ahb_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic M_CORE = 1'b0;
  localparam logic M_DMA  = 1'b1;
  typedef enum logic {ARB_IDLE, ARB_RD_WAIT} arb_state_t;
endpackage

// File: rtl/ahb_arb_grant.sv
// ahb_arb_grant: combinational two-master grant.
// AHB_ARB_ROUND_ROBIN_EN selects round-robin on the last-granted pointer; otherwise m0 has fixed priority.
module ahb_arb_grant (
`ifdef AHB_ARB_ROUND_ROBIN_EN
  input  logic last,
`endif
  input  logic req0,
  input  logic req1,
  output logic gnt,
  output logic gnt_vld
);
  always_comb begin
    gnt_vld = req0 | req1;
`ifdef AHB_ARB_ROUND_ROBIN_EN
    gnt = (req0 & req1) ? ~last : req1;
`else
    gnt = ~req0 & req1;
`endif
  end
endmodule

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: arbitrates core (m0) and DMA (m1) onto one AHB port, one transaction outstanding.
// AHB_ARB_ROUND_ROBIN_EN enables round-robin grant; default build is fixed priority to m0.
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_rd_en,
  input  logic        m0_wr_en,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wr_data,
  input  logic [1:0]  m0_size,
  output logic        m0_busy,
  output logic [31:0] m0_rd_data,
  output logic        m0_rd_vld,
  output logic        m0_err,
  input  logic        m1_rd_en,
  input  logic        m1_wr_en,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wr_data,
  input  logic [1:0]  m1_size,
  output logic        m1_busy,
  output logic [31:0] m1_rd_data,
  output logic        m1_rd_vld,
  output logic        m1_err,
  output logic        ahb_rd_en,
  output logic        ahb_wr_en,
  output logic [31:0] ahb_addr,
  output logic [31:0] ahb_wr_data,
  output logic [1:0]  ahb_size,
  input  logic [31:0] ahb_rd_data,
  input  logic        ahb_rd_vld,
  input  logic        ahb_busy,
  output logic        arb_owner
);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  arb_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic owner_q, owner_d;
  logic gnt, gnt_vld, acc, rd_done, tmo, sel_rd, sel_wr, clash;
  logic [31:0] sel_addr, sel_wd;
  logic [1:0] sel_size;
`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
`endif
  ahb_arb_grant u_grant (
`ifdef AHB_ARB_ROUND_ROBIN_EN
    .last(last_q),
`endif
    .req0(m0_rd_en | m0_wr_en),
    .req1(m1_rd_en | m1_wr_en),
    .gnt(gnt),
    .gnt_vld(gnt_vld)
  );
  // rst_n gates acceptance so nothing leaks onto the bus while reset is held
  always_comb begin
    sel_rd   = gnt ? m1_rd_en : m0_rd_en;
    sel_wr   = gnt ? m1_wr_en : m0_wr_en;
    sel_addr = gnt ? m1_addr : m0_addr;
    sel_wd   = gnt ? m1_wr_data : m0_wr_data;
    sel_size = gnt ? m1_size : m0_size;
    acc      = rst_n && state_q == ARB_IDLE && !ahb_busy && gnt_vld;
    clash    = acc && sel_rd && sel_wr;
    rd_done  = state_q == ARB_RD_WAIT && ahb_rd_vld;
    tmo      = state_q == ARB_RD_WAIT && !ahb_rd_vld && cnt_q == TMO_LAST;
    ahb_rd_en   = acc && sel_rd;
    ahb_wr_en   = acc && sel_wr && !sel_rd;
    ahb_addr    = acc ? sel_addr : '0;
    ahb_wr_data = acc ? sel_wd : '0;
    ahb_size    = acc ? sel_size : '0;
    m0_busy    = !(acc && gnt == M_CORE);
    m1_busy    = !(acc && gnt == M_DMA);
    m0_rd_vld  = (rd_done || tmo) && owner_q == M_CORE;
    m1_rd_vld  = (rd_done || tmo) && owner_q == M_DMA;
    m0_rd_data = (rd_done && owner_q == M_CORE) ? ahb_rd_data : '0;
    m1_rd_data = (rd_done && owner_q == M_DMA) ? ahb_rd_data : '0;
    m0_err     = (tmo && owner_q == M_CORE) || (clash && gnt == M_CORE);
    m1_err     = (tmo && owner_q == M_DMA) || (clash && gnt == M_DMA);
    arb_owner  = owner_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = acc ? gnt : owner_q;
    if (acc && sel_rd) begin
      state_d = ARB_RD_WAIT;
      cnt_d   = '0;
    end else if (state_q == ARB_RD_WAIT) begin
      state_d = (rd_done || tmo) ? ARB_IDLE : ARB_RD_WAIT;
      cnt_d   = &cnt_q ? cnt_q : cnt_q + 16'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      owner_q <= M_CORE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end
`ifdef AHB_ARB_ROUND_ROBIN_EN
  assign last_d = acc ? gnt : last_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= M_DMA;
    else last_q <= last_d;
  end
`endif
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter: directed scenarios plus random traffic checked against a transaction-level model.
module tb_ahb_master_arbiter;
  localparam int TMO = 4;
  logic clk = 0, rst_n = 0;
  logic rd_en[2], wr_en[2];
  logic [31:0] ad[2], wd[2];
  logic [1:0] sz[2];
  logic bsy[2], rvld[2], err[2];
  logic [31:0] rdat[2];
  logic ahb_rd_en, ahb_wr_en, ahb_rd_vld, ahb_busy, arb_owner;
  logic [31:0] ahb_addr, ahb_wr_data, ahb_rd_data;
  logic [1:0] ahb_size;
  int n_chk = 0, n_bad = 0, cyc = 0;
  bit outst;
  int own, last, start;

  always #5 clk = ~clk;

  ahb_master_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_rd_en(rd_en[0]), .m0_wr_en(wr_en[0]), .m0_addr(ad[0]), .m0_wr_data(wd[0]), .m0_size(sz[0]),
    .m0_busy(bsy[0]), .m0_rd_data(rdat[0]), .m0_rd_vld(rvld[0]), .m0_err(err[0]),
    .m1_rd_en(rd_en[1]), .m1_wr_en(wr_en[1]), .m1_addr(ad[1]), .m1_wr_data(wd[1]), .m1_size(sz[1]),
    .m1_busy(bsy[1]), .m1_rd_data(rdat[1]), .m1_rd_vld(rvld[1]), .m1_err(err[1]),
    .ahb_rd_en(ahb_rd_en), .ahb_wr_en(ahb_wr_en), .ahb_addr(ahb_addr), .ahb_wr_data(ahb_wr_data),
    .ahb_size(ahb_size), .ahb_rd_data(ahb_rd_data), .ahb_rd_vld(ahb_rd_vld), .ahb_busy(ahb_busy),
    .arb_owner(arb_owner)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    outst = 0; own = 0; last = 1;
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      rd_en[m] = 0; wr_en[m] = 0; ad[m] = '0; wd[m] = '0; sz[m] = '0;
    end
    ahb_rd_vld = 0; ahb_busy = 0; ahb_rd_data = '0;
  endtask

  task automatic req(input int m, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    rd_en[m] = r; wr_en[m] = w; ad[m] = a; wd[m] = d; sz[m] = s;
  endtask

  // inputs are already set; compare one cycle's outputs, advance the model, move past the next edge
  task automatic step();
    logic [67:0] e_ahb;
    logic [34:0] e_m[2];
    int g;
    bit r0, r1;
    #1;
    e_ahb = '0;
    e_m[0] = {1'b1, 34'b0};
    e_m[1] = {1'b1, 34'b0};
    check("owner", 128'(arb_owner), 128'(own));
    r0 = rd_en[0] || wr_en[0];
    r1 = rd_en[1] || wr_en[1];
    if (outst) begin
      if (ahb_rd_vld) begin
        e_m[own] = {1'b1, 1'b1, 1'b0, ahb_rd_data};
        outst = 0;
      end else if (cyc - start == TMO - 1) begin
        e_m[own] = {1'b1, 1'b1, 1'b1, 32'h0};
        outst = 0;
      end
    end else if (!ahb_busy && (r0 || r1)) begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
      g = (r0 && r1) ? 1 - last : (r0 ? 0 : 1);
`else
      g = r0 ? 0 : 1;
`endif
      e_ahb = {rd_en[g], wr_en[g] && !rd_en[g], ad[g], wd[g], sz[g]};
      e_m[g] = {1'b0, 1'b0, rd_en[g] && wr_en[g], 32'h0};
      own = g; last = g;
      if (rd_en[g]) begin outst = 1; start = cyc + 1; end
    end
    check("ahb", 128'({ahb_rd_en, ahb_wr_en, ahb_addr, ahb_wr_data, ahb_size}), 128'(e_ahb));
    check("m0", 128'({bsy[0], rvld[0], err[0], rdat[0]}), 128'(e_m[0]));
    check("m1", 128'({bsy[1], rvld[1], err[1], rdat[1]}), 128'(e_m[1]));
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #1;
    check("rst_out", 128'({ahb_rd_en, ahb_wr_en, ahb_addr, rvld[0], rvld[1], err[0], err[1], arb_owner}), 128'(0));
    check("rst_busy", 128'({bsy[0], bsy[1]}), 128'(2'b11));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    // single write, same-cycle issue
    req(0, 0, 1, 32'h1000, 32'hDEADBEEF, 2'd2);
    step();
    idle_inputs();
    step();
    // both masters read together
    req(0, 1, 0, 32'h2000, 32'h0, 2'd2);
    req(1, 1, 0, 32'h3000, 32'h0, 2'd1);
    step();
    step();
    step();
    ahb_rd_vld = 1; ahb_rd_data = 32'h12345678;
    step();
    ahb_rd_vld = 0;
    step();
    ahb_rd_vld = 1; ahb_rd_data = 32'hCAFEF00D;
    step();
    idle_inputs();
    step();
    // downstream busy holds off a pending m1 read
    ahb_busy = 1;
    req(1, 1, 0, 32'h4000, 32'h0, 2'd0);
    repeat (3) step();
    ahb_busy = 0;
    step();
    req(1, 0, 0, 32'h0, 32'h0, 2'd0);
    ahb_rd_vld = 1; ahb_rd_data = 32'h0BADF00D;
    step();
    idle_inputs();
    // m0 read times out, then a late rd_vld is ignored
    req(0, 1, 0, 32'h5000, 32'h0, 2'd2);
    step();
    idle_inputs();
    repeat (TMO) step();
    ahb_rd_vld = 1; ahb_rd_data = 32'h77777777;
    step();
    idle_inputs();
    // m1 read+write clash, then reset mid-read
    req(1, 1, 1, 32'h6000, 32'h11112222, 2'd2);
    step();
    idle_inputs();
    step();
    rst_n = 0;
    #1;
    check("rst_mid_out", 128'({ahb_rd_en, ahb_wr_en, rvld[0], rvld[1], err[0], err[1], rdat[1], arb_owner}), 128'(0));
    check("rst_mid_busy", 128'({bsy[0], bsy[1]}), 128'(2'b11));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    ahb_rd_vld = 1; ahb_rd_data = 32'h99999999;
    repeat (TMO + 1) step();
    idle_inputs();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < 2; m++)
        if (!(bsy[m] && (rd_en[m] || wr_en[m]) && $urandom_range(3) != 0)) begin
          rd_en[m] = $urandom_range(2) == 0;
          wr_en[m] = $urandom_range(2) == 0;
          ad[m] = $urandom;
          wd[m] = $urandom;
          sz[m] = 2'($urandom_range(2));
        end
      ahb_busy = $urandom_range(3) == 0;
      ahb_rd_vld = $urandom_range(5) == 0;
      ahb_rd_data = $urandom;
      step();
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: cycles in RD_WAIT without ahb_rd_vld before an error completion; legal range 1..65535.
REQ-002 Ports (N = 0 core, N = 1 DMA); one clock, reset asynchronous active-low:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mN_rd_en  in  1  read request.
- mN_wr_en  in  1  write request.
- mN_addr  in  32  byte address.
- mN_wr_data  in  32  write data.
- mN_size  in  2  0 = byte, 1 = half, 2 = word.
- mN_busy  out  1  request not accepted this cycle.
- mN_rd_data  out  32  read data.
- mN_rd_vld  out  1  read completion strobe.
- mN_err  out  1  error strobe.
- ahb_rd_en, ahb_wr_en  out  1  downstream strobes.
- ahb_addr, ahb_wr_data  out  32  downstream address and write data.
- ahb_size  out  2  downstream size.
- ahb_rd_data  in  32  downstream read data.
- ahb_rd_vld  in  1  downstream read-data valid.
- ahb_busy  in  1  downstream cannot accept.
- arb_owner  out  1  master owning the outstanding read, or last granted.

Function
REQ-003 States: IDLE, RD_WAIT; at most one transaction outstanding.
REQ-004 Master N requests when mN_rd_en|mN_wr_en; request held by master while mN_busy=1.
REQ-005 Acceptance (combinational, same cycle) requires all of: state=IDLE, ahb_busy=0, N granted; then mN_busy=0.
- All other cycles: mN_busy=1.
REQ-006 On acceptance, ahb_rd_en/ahb_wr_en equal granted master's strobes for that cycle only.
- ahb_addr/ahb_wr_data/ahb_size muxed from granted master.
- All ahb_* outputs 0 when nothing is accepted.
REQ-007 If mN_rd_en and mN_wr_en are both 1: the read is issued, the write is dropped, and mN_err pulses 1 cycle.
REQ-008 Write completes on acceptance; state stays IDLE; owner may change next cycle.
REQ-009 Read acceptance: IDLE->RD_WAIT, arb_owner<=N, timeout counter<=0.
REQ-010 In RD_WAIT with ahb_rd_vld=1:
- mOwner_rd_vld=1 and mOwner_rd_data=ahb_rd_data, same cycle (zero latency).
- Next state IDLE.
- A new grant is allowed only from the following cycle.
REQ-011 In RD_WAIT without ahb_rd_vld, counter increments.
- When counter reaches TIMEOUT_CYCLES-1: mOwner_rd_vld=1, mOwner_rd_data=0, mOwner_err=1 for one cycle; next state IDLE.
- ahb_rd_vld arriving on that same cycle wins: normal completion, no err.
REQ-012 ahb_rd_vld received in IDLE is ignored; no output strobe.
REQ-013 mN_rd_data=0 whenever mN_rd_vld=0; the non-owner's rd_vld/rd_data/err stay 0.
REQ-014 Counter is 16 bits and saturates; it never wraps.

Reset
REQ-015 rst_n low asynchronously forces:
- state IDLE, counter 0, arb_owner 0;
- round-robin pointer "last granted" = 1;
- all outputs 0, except mN_busy, which follows REQ-005 (0 only for an accepted request).
REQ-016 Reset mid-read abandons the transaction; no completion strobe is produced after release.

Configuration
REQ-017 Macro AHB_ARB_ROUND_ROBIN_EN:
- Defined: with both masters requesting, grant goes to the master not last granted; pointer updates on every acceptance.
- Undefined: fixed priority, m0 always wins; pointer logic absent.
- In both modes, a lone requester is granted.

Structure
REQ-018 Shared package ahb_pkg holds:
- size encodings SIZE_BYTE/HALF/WORD;
- state enum ARB_IDLE/ARB_RD_WAIT;
- master index constants M_CORE=0, M_DMA=1.
REQ-019 One sub-module, ahb_arb_grant: combinational grant from two requests and last-granted pointer, containing the macro-dependent logic.
- The FSM, counter and muxes live in the top module.

Verification
REQ-020 m0 write addr 0x1000 data 0xDEADBEEF size 2, ahb_busy=0 -> same-cycle ahb_wr_en=1 with those values, m0_busy=0, state IDLE.
REQ-021 Both masters read simultaneously, round-robin build, after reset:
- m0 granted first; m1_busy=1 until m0's ahb_rd_vld (data 0x12345678) reaches m0_rd_data;
- m1 granted the cycle after;
- fixed build: m0 keeps winning while it requests.
REQ-022 ahb_busy=1 for 3 cycles with m1 read pending -> m1_busy=1 for 3 cycles, no ahb_rd_en; accepted on the 4th cycle.
REQ-023 TIMEOUT_CYCLES=4, m0 read with ahb_rd_vld never asserted -> 4 cycles in RD_WAIT, then m0_rd_vld=1, m0_err=1, m0_rd_data=0; a late ahb_rd_vld is ignored.
REQ-024 m1 asserts rd_en and wr_en together -> read issued, m1_err pulses 1 cycle; rst_n low during RD_WAIT -> all outputs 0 immediately, no completion after release.
